// File: rtl/queue_8x8.sv
// Eight-entry, 8-bit synchronous FIFO with occupancy count and full flag.
// Enqueues to a full queue are dropped unless a dequeue frees a slot on the same edge.
module queue_8x8 (
   input  logic       clock_10,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       enq_in,
   input  logic       deq_in,
   output logic [7:0] data_out,
   output logic [3:0] len_out,
   output logic       status_out
);

   logic [7:0] mem_q [8];
   logic [7:0] mem_d [8];
   logic [2:0] wr_ptr_q, wr_ptr_d;
   logic [2:0] rd_ptr_q, rd_ptr_d;
   logic [3:0] count_q, count_d;
   logic [7:0] data_out_q, data_out_d;
   logic       full, empty;
   logic       enq_ok, deq_ok;

   assign full  = (count_q == 4'd8);
   assign empty = (count_q == 4'd0);

   // When full, a simultaneous read frees the slot being written this edge.
   assign enq_ok = enq_in && (!full || deq_in);
   assign deq_ok = deq_in && !empty;

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      data_out_d = data_out_q;
      count_d    = count_q;

      if (enq_ok) begin
         mem_d[wr_ptr_q] = data_in;
         wr_ptr_d        = wr_ptr_q + 3'd1;
      end
      if (deq_ok) begin
         data_out_d = mem_q[rd_ptr_q];
         rd_ptr_d   = rd_ptr_q + 3'd1;
      end

      unique case ({enq_ok, deq_ok})
         2'b10:   count_d = count_q + 4'd1;
         2'b01:   count_d = count_q - 4'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock_10 or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= 3'd0;
         rd_ptr_q   <= 3'd0;
         count_q    <= 4'd0;
         data_out_q <= 8'h00;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         data_out_q <= data_out_d;
      end
   end

   // Storage needs no reset; pointers and count define what is valid.
   always_ff @(posedge clock_10) begin
      mem_q <= mem_d;
   end

   assign data_out   = data_out_q;
   assign len_out    = count_q;
   assign status_out = full;

endmodule

// File: tb/tb_queue_8x8.sv
// Self-checking bench for queue_8x8: directed vector table, async reset sequences,
// and randomized traffic against a queue-based reference model.
`timescale 1us/1ns
module tb_queue_8x8;

   logic       clock_10;
   logic       reset;
   logic [7:0] data_in;
   logic       enq_in;
   logic       deq_in;
   logic [7:0] data_out;
   logic [3:0] len_out;
   logic       status_out;

   int n_checks = 0;
   int n_fail   = 0;

   queue_8x8 dut (
      .clock_10   (clock_10),
      .reset      (reset),
      .data_in    (data_in),
      .enq_in     (enq_in),
      .deq_in     (deq_in),
      .data_out   (data_out),
      .len_out    (len_out),
      .status_out (status_out)
   );

   initial clock_10 = 1'b0;
   always #50 clock_10 = ~clock_10;

   typedef struct {
      logic       enq;
      logic       deq;
      logic [7:0] din;
      logic [3:0] len;
      logic       full;
      logic [7:0] dout;
   } vec_t;

   vec_t tbl[$];

   // Reference model state
   logic [7:0] model_q[$];
   logic [7:0] model_dout;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic e, input logic d, input logic [7:0] di,
                      input logic [3:0] l, input logic f, input logic [7:0] o);
      vec_t v;
      v.enq = e; v.deq = d; v.din = di; v.len = l; v.full = f; v.dout = o;
      tbl.push_back(v);
   endtask

   // Drive inputs on the falling edge, then let one rising edge pass and settle.
   task automatic cycle(input logic e, input logic d, input logic [7:0] di);
      @(negedge clock_10);
      enq_in  = e;
      deq_in  = d;
      data_in = di;
      @(posedge clock_10);
      #1;
   endtask

   task automatic model_step(input logic e, input logic d, input logic [7:0] di);
      int sz;
      bit do_enq, do_deq;
      sz     = model_q.size();
      do_deq = d && (sz > 0);
      do_enq = e && ((sz < 8) || d);
      if (do_deq) model_dout = model_q.pop_front();
      if (do_enq) model_q.push_back(di);
   endtask

   task automatic check_model(input string tag);
      check({tag, "_len"},  {4'd0, len_out}, {4'd0, 4'(model_q.size())});
      check({tag, "_full"}, {7'd0, status_out}, {7'd0, model_q.size() == 8});
      check({tag, "_dout"}, data_out, model_dout);
   endtask

   initial begin
      logic [7:0] b;
      reset   = 1'b0;
      enq_in  = 1'b0;
      deq_in  = 1'b0;
      data_in = 8'h00;

      // ---------------- Reset state ----------------
      repeat (3) @(posedge clock_10);
      #1;
      check("rst_len",  {4'd0, len_out}, 8'd0);
      check("rst_full", {7'd0, status_out}, 8'd0);
      check("rst_dout", data_out, 8'h00);
      @(negedge clock_10);
      reset = 1'b1;

      // ---------------- Directed vector table ----------------
      add(0, 1, 8'h00, 0, 0, 8'h00);                 // deq on empty ignored
      for (int i = 1; i <= 9; i++) begin             // fill 11..99, 99 dropped
         b = 8'(i * 8'h11);
         add(1, 0, b, 4'((i > 8) ? 8 : i), i >= 8, 8'h00);
      end
      for (int i = 1; i <= 5; i++) begin             // drain 11..55
         b = 8'(i * 8'h11);
         add(0, 1, 8'h00, 4'(8 - i), 0, b);
      end
      add(1, 0, 8'hAA, 4, 0, 8'h55);                 // wrap: AA..EE accepted
      add(1, 0, 8'hBB, 5, 0, 8'h55);
      add(1, 0, 8'hCC, 6, 0, 8'h55);
      add(1, 0, 8'hDD, 7, 0, 8'h55);
      add(1, 0, 8'hEE, 8, 1, 8'h55);
      add(1, 0, 8'hFF, 8, 1, 8'h55);                 // dropped
      add(1, 0, 8'h10, 8, 1, 8'h55);                 // dropped
      add(0, 1, 8'h00, 7, 0, 8'h66);
      add(0, 1, 8'h00, 6, 0, 8'h77);
      add(0, 1, 8'h00, 5, 0, 8'h88);
      add(0, 1, 8'h00, 4, 0, 8'hAA);
      add(0, 1, 8'h00, 3, 0, 8'hBB);
      add(0, 1, 8'h00, 2, 0, 8'hCC);
      add(0, 1, 8'h00, 1, 0, 8'hDD);
      add(0, 1, 8'h00, 0, 0, 8'hEE);
      add(1, 1, 8'h42, 1, 0, 8'hEE);                 // simultaneous on empty
      add(1, 0, 8'h43, 2, 0, 8'hEE);
      add(1, 0, 8'h44, 3, 0, 8'hEE);
      add(1, 1, 8'h45, 3, 0, 8'h42);                 // simultaneous at len 3
      add(0, 1, 8'h00, 2, 0, 8'h43);
      add(0, 1, 8'h00, 1, 0, 8'h44);
      add(0, 1, 8'h00, 0, 0, 8'h45);
      for (int i = 1; i <= 8; i++) add(1, 0, 8'(i), 4'(i), i == 8, 8'h45);
      add(1, 1, 8'h09, 8, 1, 8'h01);                 // simultaneous when full
      for (int i = 2; i <= 9; i++) add(0, 1, 8'h00, 4'(9 - i), 0, 8'(i));

      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].enq, tbl[i].deq, tbl[i].din);
         check($sformatf("vec%0d_len", i),  {4'd0, len_out}, {4'd0, tbl[i].len});
         check($sformatf("vec%0d_full", i), {7'd0, status_out}, {7'd0, tbl[i].full});
         check($sformatf("vec%0d_dout", i), data_out, tbl[i].dout);
      end

      // ---------------- Async reset mid-fill ----------------
      for (int i = 0; i < 6; i++) cycle(1, 0, 8'hC0 + 8'(i));
      cycle(0, 1, 8'h00);
      check("pre_rst_len",  {4'd0, len_out}, 8'd5);
      check("pre_rst_dout", data_out, 8'hC0);
      enq_in = 1'b0;
      deq_in = 1'b0;
      #20;
      reset = 1'b0;
      #5;
      check("async_len",  {4'd0, len_out}, 8'd0);
      check("async_full", {7'd0, status_out}, 8'd0);
      check("async_dout", data_out, 8'h00);
      @(negedge clock_10);
      reset = 1'b1;
      cycle(0, 1, 8'h00);
      check("post_rst_len",  {4'd0, len_out}, 8'd0);
      check("post_rst_dout", data_out, 8'h00);

      // ---------------- Randomized traffic vs model ----------------
      model_q.delete();
      model_dout = 8'h00;
      for (int i = 0; i < 600; i++) begin
         logic e, d;
         logic [7:0] di;
         // Shift the enq/deq bias every 100 cycles so full and empty both get exercised.
         e  = ($urandom_range(0, 99) < (((i / 100) % 2 == 0) ? 70 : 30));
         d  = ($urandom_range(0, 99) < (((i / 100) % 2 == 0) ? 30 : 70));
         di = 8'($urandom);
         cycle(e, d, di);
         model_step(e, d, di);
         check_model($sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
